// File: rtl/cpu_data_axi_bridge.sv
// Bridges the core's SRAM-like data port to single-beat AXI4 reads and writes.
// Only one transaction is in flight; the core is told to wait until DONE has passed.
module cpu_data_axi_bridge #(
  parameter int            ID_W  = 4,
  parameter logic [ID_W-1:0] RD_ID = '0,
  parameter logic [ID_W-1:0] WR_ID = ID_W'(1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [2:0]      data_size,
  input  logic [3:0]      data_wstrb,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic            data_addr_ok,
  output logic [31:0]     data_rdata,
  output logic            data_data_ok,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_size, w_size_enc;
  logic [3:0]  r_wstrb;
  logic        r_aw_done, r_w_done;
  logic        w_accept, w_aw_fire, w_w_fire;

  // Response IDs and error codes are deliberately not inspected.
  logic w_unused;
  assign w_unused = ^{rid, rresp, bid, bresp};

  assign w_size_enc = (data_size == 3'd0) ? 3'd0 :
                      (data_size == 3'd1) ? 3'd1 : 3'd2;
  assign w_accept   = data_req && data_addr_ok;
  assign w_aw_fire  = awvalid && awready;
  assign w_w_fire   = wvalid && wready;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= data_addr;
        r_size    <= w_size_enc;
        r_wstrb   <= data_wstrb;
        r_wdata   <= data_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      // Remember each write channel's handshake so it is never re-issued.
      if (r_state == S_WR_AW) begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
      if (r_state == S_RD_D && rvalid && rlast) r_rdata <= rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = data_wr ? S_WR_AW : S_RD_A;
      S_RD_A:  if (arready) w_next = S_RD_D;
      S_RD_D:  if (rvalid && rlast) w_next = S_DONE;
      S_WR_AW: if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_WR_B;
      S_WR_B:  if (bvalid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (r_state)
      S_IDLE:  data_addr_ok = 1'b1;
      S_RD_A:  arvalid = 1'b1;
      S_RD_D:  rready = 1'b1;
      S_WR_AW: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
      end
      S_WR_B:  bready = 1'b1;
      S_DONE:  data_data_ok = 1'b1;
      default: ;
    endcase
  end

  assign data_rdata = r_rdata;
  assign arid       = RD_ID;
  assign araddr     = r_addr;
  assign arlen      = 8'd0;
  assign arsize     = r_size;
  assign arburst    = 2'b01;
  assign awid       = WR_ID;
  assign awaddr     = r_addr;
  assign awlen      = 8'd0;
  assign awsize     = r_size;
  assign awburst    = 2'b01;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign wlast      = 1'b1;

endmodule

// File: tb/tb_cpu_data_axi_bridge.sv
// Self-checking bench for cpu_data_axi_bridge: cycle-driven AXI responder tasks
// plus a completion scoreboard that checks data_rdata on every data_data_ok.
module tb_cpu_data_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        data_req, data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rd;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  cpu_data_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Scoreboard: every completion must match the oldest pending expectation.
  always @(negedge clk) begin
    if (resetn && data_data_ok) begin
      checks++;
      n_done++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: data_data_ok=1 with no pending request");
      end else begin
        mon_exp = sb_q.pop_front();
        if (data_rdata !== mon_exp) begin
          errors++;
          $display("FAIL done_rdata: got %h expected %h", data_rdata, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_data_ok} !== 6'b0 || data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: ar/r/aw/w/b/ok=%b addr_ok=%b expected 000000 1",
               {arvalid, rready, awvalid, wvalid, bready, data_data_ok}, data_addr_ok);
    end
    checks++;
    if (data_rdata !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 || arsize !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h strb=%h size=%0d expected all 0",
               data_rdata, araddr, wdata, wstrb, arsize);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [2:0] exp_size,
                         input logic [31:0] rd, input logic [1:0] resp, input int ar_dly, input int r_dly,
                         input bit nolast_first, input bit hold_wr, input logic [31:0] n_addr,
                         input logic [31:0] n_data, input logic [3:0] n_strb, input logic [2:0] n_size);
    int d0 = n_done;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rd_addr_ok_idle: got %b expected 1", data_addr_ok);
    end
    data_req = 1'b1; data_wr = 1'b0; data_addr = addr; data_size = size;
    data_wstrb = 4'hF; data_wdata = $urandom;
    sb_q.push_back(rd);
    last_rd = rd;
    step();
    if (hold_wr) begin
      data_wr = 1'b1; data_addr = n_addr; data_wdata = n_data; data_wstrb = n_strb; data_size = n_size;
    end else data_req = 1'b0;
    for (int c = 0; c <= ar_dly; c++) begin
      arready = (c == ar_dly);
      checks++;
      if (arvalid !== 1'b1 || araddr !== addr || arsize !== exp_size || arlen !== 8'd0 || arburst !== 2'b01 ||
          arid !== 4'd0 || awvalid !== 1'b0 || wvalid !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL rd_ar_chan: arvalid=%b addr=%h size=%0d len=%0d burst=%b id=%0d awv=%b wv=%b aok=%b expected 1 %h %0d 0 01 0 0 0 0",
                 arvalid, araddr, arsize, arlen, arburst, arid, awvalid, wvalid, data_addr_ok, addr, exp_size);
      end
      step();
    end
    arready = 1'b0;
    if (nolast_first) begin
      rvalid = 1'b1; rlast = 1'b0; rdata = ~rd; rresp = 2'b00;
      checks++;
      if (rready !== 1'b1) begin
        errors++; $display("FAIL rd_nolast_rready: got %b expected 1", rready);
      end
      step();
    end
    for (int c = 0; c <= r_dly; c++) begin
      rvalid = (c == r_dly); rlast = 1'b1; rresp = resp;
      rdata = (c == r_dly) ? rd : 32'hBAD0_0000;
      checks++;
      if (rready !== 1'b1 || arvalid !== 1'b0 || data_data_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL rd_r_wait: rready=%b arvalid=%b data_ok=%b addr_ok=%b expected 1 0 0 0",
                 rready, arvalid, data_data_ok, data_addr_ok);
      end
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    checks++;
    if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL rd_done: data_ok=%b addr_ok=%b rready=%b expected 1 0 0", data_data_ok, data_addr_ok, rready);
    end
    step();
    checks++;
    if (data_data_ok !== 1'b0 || data_addr_ok !== 1'b1 || n_done != d0 + 1) begin
      errors++;
      $display("FAIL rd_after_done: data_ok=%b addr_ok=%b completions=%0d expected 0 1 %0d",
               data_data_ok, data_addr_ok, n_done - d0, 1);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [2:0] exp_size,
                          input logic [3:0] strb, input logic [31:0] dat,
                          input int aw_dly, input int w_dly, input int b_dly);
    int d0 = n_done;
    int aw_hs = 0;
    int w_hs = 0;
    int m = (aw_dly > w_dly) ? aw_dly : w_dly;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL wr_addr_ok_idle: got %b expected 1", data_addr_ok);
    end
    data_req = 1'b1; data_wr = 1'b1; data_addr = addr; data_size = size; data_wstrb = strb; data_wdata = dat;
    sb_q.push_back(last_rd);
    step();
    data_req = 1'b0;
    for (int c = 0; c <= m + 1; c++) begin
      awready = (c >= aw_dly); wready = (c >= w_dly);
      if (c == m + 1) begin
        awready = 1'b1; wready = 1'b1;
      end
      checks++;
      if (awvalid !== (c <= aw_dly) || wvalid !== (c <= w_dly) || awaddr !== addr || awsize !== exp_size ||
          awlen !== 8'd0 || awburst !== 2'b01 || awid !== 4'd1 || wdata !== dat || wstrb !== strb ||
          wlast !== 1'b1 || arvalid !== 1'b0 || bready !== (c == m + 1)) begin
        errors++;
        $display("FAIL wr_aw_w_chan c=%0d: awv=%b wv=%b addr=%h size=%0d len=%0d burst=%b id=%0d wdata=%h strb=%b wlast=%b arv=%b bready=%b expected %b %b %h %0d 0 01 1 %h %b 1 0 %b",
                 c, awvalid, wvalid, awaddr, awsize, awlen, awburst, awid, wdata, wstrb, wlast, arvalid, bready,
                 c <= aw_dly, c <= w_dly, addr, exp_size, dat, strb, c == m + 1);
      end
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (c <= m) step();
    end
    awready = 1'b0; wready = 1'b0;
    for (int c = 0; c <= b_dly; c++) begin
      bvalid = (c == b_dly); bresp = 2'b10;
      checks++;
      if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || data_data_ok !== 1'b0) begin
        errors++;
        $display("FAIL wr_b_wait: bready=%b awv=%b wv=%b data_ok=%b expected 1 0 0 0",
                 bready, awvalid, wvalid, data_data_ok);
      end
      step();
    end
    bvalid = 1'b0;
    checks++;
    if (data_data_ok !== 1'b1 || bready !== 1'b0 || aw_hs != 1 || w_hs != 1) begin
      errors++;
      $display("FAIL wr_done: data_ok=%b bready=%b aw_beats=%0d w_beats=%0d expected 1 0 1 1",
               data_data_ok, bready, aw_hs, w_hs);
    end
    step();
    checks++;
    if (data_data_ok !== 1'b0 || data_addr_ok !== 1'b1 || n_done != d0 + 1) begin
      errors++;
      $display("FAIL wr_after_done: data_ok=%b addr_ok=%b completions=%0d expected 0 1 1",
               data_data_ok, data_addr_ok, n_done - d0);
    end
  endtask

  task automatic test_reads();
    do_read(32'h1FC0_0000, 3'd2, 3'd2, 32'hDEADBEEF, 2'b00, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    do_read(32'h0000_1002, 3'd1, 3'd1, 32'h0000_5A5A, 2'b00, 2, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    do_read(32'h0000_2001, 3'd5, 3'd2, 32'hCAFE_F00D, 2'b00, 1, 3, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
  endtask

  task automatic test_writes();
    do_write(32'h8000_0003, 3'd0, 3'd0, 4'b1000, 32'hAA00_0000, 0, 2, 3);
    do_write(32'h8000_0010, 3'd2, 3'd2, 4'b1111, 32'h1234_ABCD, 0, 0, 5);
    do_write(32'h8000_0022, 3'd1, 3'd1, 4'b1100, 32'h5555_0000, 3, 1, 0);
    do_write(32'h8000_0030, 3'd7, 3'd2, 4'b1111, 32'h0F0F_0F0F, 1, 1, 2);
  endtask

  task automatic test_back_to_back();
    do_read(32'h1000_0040, 3'd2, 3'd2, 32'h600D_CAFE, 2'b00, 0, 0, 1'b0, 1'b1,
            32'h2000_0044, 32'h7777_8888, 4'b0011, 3'd1);
    do_write(32'h2000_0044, 3'd1, 3'd1, 4'b0011, 32'h7777_8888, 1, 0, 1);
    checks++;
    if (data_rdata !== 32'h600D_CAFE) begin
      errors++; $display("FAIL b2b_rdata_kept: got %h expected 600dcafe", data_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = n_done;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h3000_0000; data_size = 3'd2;
    sb_q.push_back(32'h9999_9999);
    step();
    data_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_rd_d: rready=%b expected 1", rready);
    end
    resetn = 1'b0;
    step();
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || data_data_ok !== 1'b0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_abort: arvalid=%b rready=%b data_ok=%b rdata=%h expected 0 0 0 0",
               arvalid, rready, data_data_ok, data_rdata);
    end
    sb_q.delete();
    last_rd = 32'h0;
    resetn = 1'b1;
    step();
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rst_mid_addr_ok: got %b expected 1", data_addr_ok);
    end
    repeat (4) step();
    checks++;
    if (n_done != d0 || data_data_ok !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done: completions=%0d data_ok=%b arvalid=%b expected 0 0 0",
               n_done - d0, data_data_ok, arvalid);
    end
  endtask

  task automatic test_slverr();
    do_read(32'h4000_0008, 3'd2, 3'd2, 32'h1234_5678, 2'b10, 0, 2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    checks++;
    if (data_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL slverr_rdata: got %h expected 12345678", data_rdata);
    end
  endtask

  initial begin
    resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 3'd0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; arready = 1'b0; rid = 4'd0; rdata = 32'h0;
    rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    bid = 4'd1; bresp = 2'b00; bvalid = 1'b0; last_rd = 32'h0;
    test_reset();
    test_reads();
    test_writes();
    test_back_to_back();
    test_reset_mid();
    test_slverr();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drained: %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
